// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Receives a byte stream (16-bit big-endian word count followed by
//   count x 4 big-endian instruction bytes) over a valid/ready handshake.
//   Each assembled word is written sequentially into the instruction memory.
//   The CPU is held in reset until the whole program is in memory.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          begins a load (honoured in IDLE, DONE, ERROR)
//   abort          returns to IDLE from any state; wins over start
//   in_data        stream byte
//   in_valid       in_data valid
//   in_ready       byte accepted this cycle (LEN_HI, LEN_LO, DATA)
//   imem_we        instruction memory write strobe (WRITE only)
//   imem_addr      instruction memory byte address
//   imem_wdata     instruction word being written
//   cpu_reset      active-high reset to PC/CPU, low only in DONE
//   done           load completed successfully
//   error          load rejected (bad length)
//   words_written  words written in the current load
module imem_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam logic [15:0] MAX_W16 = MAX_WORDS[15:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] ww_q, ww_d;

    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] ww_inc;

    assign xfer     = in_valid & in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign ww_inc   = ww_q + 16'd1;

    // State register and datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= BASE_ADDR;
            ww_q       <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            ww_q       <= ww_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (start) state_d = S_LEN_HI;
                S_LEN_HI: if (xfer) state_d = S_LEN_LO;
                S_LEN_LO: begin
                    if (xfer) begin
                        if (len_full == 16'd0 || len_full > MAX_W16)
                            state_d = S_ERROR;
                        else
                            state_d = S_DATA;
                    end
                end
                S_DATA:   if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
                S_WRITE:  state_d = (ww_inc == len_q) ? S_DONE : S_DATA;
                S_DONE:   if (start) state_d = S_LEN_HI;
                S_ERROR:  if (start) state_d = S_LEN_HI;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values
    always_comb begin
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        ww_d       = ww_q;
        unique case (state_q)
            S_IDLE: begin
                ww_d   = '0;
                addr_d = BASE_ADDR;
            end
            S_LEN_HI: if (xfer) len_d[15:8] = in_data;
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    byte_idx_d = '0;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Completed word is only published when it will be written.
                    if (byte_idx_q == 2'd3 && !abort)
                        wdata_d = {shift_q, in_data};
                end
            end
            // The write happens this cycle regardless of abort, so the
            // counters still advance; IDLE clears them afterwards.
            S_WRITE: begin
                ww_d   = ww_inc;
                addr_d = addr_q + 32'd4;
            end
            S_DONE, S_ERROR: begin
                if (start && !abort) begin
                    ww_d   = '0;
                    addr_d = BASE_ADDR;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        imem_we   = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
            S_WRITE:                    imem_we  = 1'b1;
            S_DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            S_ERROR:                    error    = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    imem_stream_loader #(
        .BASE_ADDR(32'd0),
        .MAX_WORDS(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .done(done),
        .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%h/%h expected=none", imem_addr, imem_wdata);
            end
            if (exp_q.size() != 0) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, e[63:32]);
                chk("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        guard = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int gap);
        exp_q.push_back({addr, w});
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_ww", {16'd0, words_written}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // abort beats start
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_ready", {31'd0, in_ready}, 32'd0);

        // Basic back-to-back two-word load
        pulse_start();
        chk("lenhi_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'd0, 32'hF8400020, 0);
        send_word(32'd4, 32'h8B020021, 0);
        wait_done("basic_done");
        chk("basic_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("basic_ww", {16'd0, words_written}, 32'd2);
        chk("basic_pending", exp_q.size(), 32'd0);

        // Reload from DONE, same stream with in_valid gaps
        pulse_start();
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_ww", {16'd0, words_written}, 32'd0);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_word(32'd0, 32'hF8400020, 1);
        send_word(32'd4, 32'h8B020021, 1);
        wait_done("gap_done");
        chk("gap_ww", {16'd0, words_written}, 32'd2);
        chk("gap_pending", exp_q.size(), 32'd0);

        // Reload with one-word stream
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'd0, 32'h12345678, 0);
        wait_done("one_done");
        chk("one_ww", {16'd0, words_written}, 32'd1);

        // Length 0 rejected
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("len0_error", {31'd0, error}, 32'd1);
        chk("len0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("len0_ready", {31'd0, in_ready}, 32'd0);
        chk("len0_done", {31'd0, done}, 32'd0);

        // Length MAX+1 rejected, started from ERROR
        pulse_start();
        chk("err_restart", {31'd0, error}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        repeat (2) @(negedge clk);
        chk("len65_error", {31'd0, error}, 32'd1);
        chk("len65_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        pulse_abort();
        chk("err_abort", {31'd0, error}, 32'd0);
        chk("err_abort_ready", {31'd0, in_ready}, 32'd0);

        // Abort mid-word, then a clean one-word load
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        pulse_abort();
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("abort_we", {31'd0, imem_we}, 32'd0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'd0, 32'hDEADBEEF, 0);
        wait_done("abort_reload_done");

        // Maximum length accepted
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        for (int i = 0; i < 64; i++) begin
            w = {i[7:0], i[7:0] ^ 8'hA5, ~i[7:0], i[7:0] + 8'd3};
            send_word(32'(i * 4), w, 0);
        end
        wait_done("max_done");
        chk("max_ww", {16'd0, words_written}, 32'd64);
        chk("max_addr_next", imem_addr, 32'd256);
        chk("max_pending", exp_q.size(), 32'd0);

        // Asynchronous reset during WRITE
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_word(32'd0, 32'hCAFEF00D, 0);
        chk("pre_rst_we", {31'd0, imem_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("arst_ww", {16'd0, words_written}, 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("post_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("post_rst_pending", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
